serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_rx.sv | 173 +++++++++++++++++
 tb/tb_serial_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// serial_rx: asynchronous serial receiver, 1 start bit, 8 data bits LSB first,
// optional even parity bit, 1 stop bit. The line is oversampled at
// CLKS_PER_BIT clocks per bit. The start bit is checked at its midpoint, and
// every later bit is sampled one full bit period after the previous sample.
// Optional feature: define SERIAL_RX_PARITY_EN to add the PARITY state and the
// parity_err output.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
`ifdef SERIAL_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic          rx_meta;
    logic          rx_s;
    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic [2:0]    bit_idx, next_bit_idx;
    logic [7:0]    shift, next_shift;
    logic [7:0]    next_data;
    logic          next_valid;
    logic          next_frame_err;
    logic          wait_high, next_wait_high;
`ifdef SERIAL_RX_PARITY_EN
    logic          par_bad, next_par_bad;
    logic          next_parity_err;
`endif

    // Two-flop synchronizer bringing the asynchronous line into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            wait_high <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            bit_idx   <= next_bit_idx;
            shift     <= next_shift;
            data      <= next_data;
            valid     <= next_valid;
            frame_err <= next_frame_err;
            wait_high <= next_wait_high;
`ifdef SERIAL_RX_PARITY_EN
            par_bad    <= next_par_bad;
            parity_err <= next_parity_err;
`endif
        end
    end

    // Next-state logic: the line must be seen high before a start is accepted
    always_comb begin
        next_state     = state;
        next_cnt       = cnt + CW'(1);
        next_bit_idx   = bit_idx;
        next_shift     = shift;
        next_data      = data;
        next_valid     = 1'b0;
        next_frame_err = 1'b0;
        next_wait_high = wait_high;
`ifdef SERIAL_RX_PARITY_EN
        next_par_bad    = par_bad;
        next_parity_err = 1'b0;
`endif
        case (state)
            IDLE: begin
                next_cnt     = '0;
                next_bit_idx = 3'd0;
                if (wait_high) begin
                    if (rx_s) begin
                        next_wait_high = 1'b0;
                    end
                end else if (!rx_s) begin
                    next_state = START;
`ifdef SERIAL_RX_PARITY_EN
                    next_par_bad = 1'b0;
`endif
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    next_cnt   = '0;
                    next_state = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    next_cnt   = '0;
                    next_shift = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end else begin
                        next_bit_idx = bit_idx + 3'd1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_LAST) begin
                    next_cnt   = '0;
                    next_state = STOP;
                    if (rx_s != ^shift) begin
                        next_par_bad = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_LAST) begin
                    next_cnt   = '0;
                    next_state = IDLE;
                    if (!rx_s) begin
                        next_frame_err = 1'b1;
                        next_wait_high = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (par_bad) begin
                        next_parity_err = 1'b1;
`endif
                    end else begin
                        next_valid = 1'b1;
                        next_data  = shift;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed frames for serial_rx; expected pulses are queued when
// a frame is launched and a monitor compares them as the DUT produces pulses.
// Define SERIAL_RX_PARITY_EN to exercise the parity build.
module tb_serial_rx;

    localparam int CLKS = 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif
    localparam int LAT = 2 + CLKS / 2 + 9 * CLKS + (PARITY_ON ? CLKS : 0);

    localparam int K_VALID = 0;
    localparam int K_FRAME = 1;
    localparam int K_PARITY = 2;
    localparam int K_NONE = -1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       perr_sig;

`ifdef SERIAL_RX_PARITY_EN
    logic parity_err;
    assign perr_sig = parity_err;
`else
    assign perr_sig = 1'b0;
`endif

    serial_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       expq[$];
    exp_t       mon_exp;
    int         mon_kind;
    int         total_checks = 0;
    int         bad_checks = 0;
    logic [7:0] last_good = 8'h00;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input int kind, input logic [7:0] b);
        exp_t e;
        e.kind = kind;
        e.data = (kind == K_VALID) ? b : last_good;
        e.at   = cyc + 1 + LAT;
        if (kind == K_VALID) last_good = b;
        expq.push_back(e);
    endtask

    // Caller must be sitting on a negedge; one full frame is driven
    task automatic applyStimulus(input logic [7:0] b, input logic bad_parity,
                                 input logic stop_bit, input int kind);
        if (kind != K_NONE) pushExpect(kind, b);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        if (PARITY_ON) begin
            rx = (^b) ^ bad_parity;
            repeat (CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CLKS) @(negedge clk);
    endtask

    // Monitor: every pulse is matched against the head of the expectation queue
    always @(negedge clk) begin
        if (!rst && (valid || frame_err || perr_sig)) begin
            mon_kind = valid ? K_VALID : (frame_err ? K_FRAME : K_PARITY);
            total_checks++;
            if ($countones({valid, frame_err, perr_sig}) != 1) begin
                bad_checks++;
                $display("[TB] FAIL exclusive pulses: got v=%b f=%b p=%b, expected one-hot",
                         valid, frame_err, perr_sig);
            end
            total_checks++;
            if (expq.size() == 0) begin
                bad_checks++;
                $display("[TB] FAIL unexpected pulse: got kind %0d at cycle %0d, expected none",
                         mon_kind, cyc);
            end else begin
                mon_exp = expq.pop_front();
                if (mon_kind != mon_exp.kind) begin
                    bad_checks++;
                    $display("[TB] FAIL pulse kind: got %0d, expected %0d", mon_kind, mon_exp.kind);
                end
                total_checks++;
                if (cyc != mon_exp.at) begin
                    bad_checks++;
                    $display("[TB] FAIL pulse cycle: got %0d, expected %0d", cyc, mon_exp.at);
                end
                total_checks++;
                if (data !== mon_exp.data) begin
                    bad_checks++;
                    $display("[TB] FAIL pulse data: got %h, expected %h", data, mon_exp.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("reset data", data, 8'h00);
        checkOutput("reset valid", {7'b0, valid}, 8'h00);
        checkOutput("reset frame_err", {7'b0, frame_err}, 8'h00);

        $display("[TB] good byte A5");
        applyStimulus(8'hA5, 1'b0, 1'b1, K_VALID);
        repeat (20) @(negedge clk);

        $display("[TB] byte 3C with low stop bit");
        applyStimulus(8'h3C, 1'b0, 1'b0, K_FRAME);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("data after frame error", data, 8'hA5);

        $display("[TB] 5-cycle glitch then FF");
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        applyStimulus(8'hFF, 1'b0, 1'b1, K_VALID);
        repeat (20) @(negedge clk);

        $display("[TB] back-to-back 01, 80");
        applyStimulus(8'h01, 1'b0, 1'b1, K_VALID);
        applyStimulus(8'h80, 1'b0, 1'b1, K_VALID);
        repeat (20) @(negedge clk);

        $display("[TB] reset in mid-frame");
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("data in reset", data, 8'h00);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (30) @(negedge clk);
        applyStimulus(8'h5A, 1'b0, 1'b1, K_VALID);
        repeat (20) @(negedge clk);

        $display("[TB] line held low");
        pushExpect(K_FRAME, 8'h00);
        rx = 1'b0;
        repeat (400) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("data after held low", data, 8'h5A);

`ifdef SERIAL_RX_PARITY_EN
        $display("[TB] parity checks on 07");
        applyStimulus(8'h07, 1'b1, 1'b1, K_PARITY);
        repeat (20) @(negedge clk);
        checkOutput("data after parity error", data, 8'h5A);
        applyStimulus(8'h07, 1'b0, 1'b1, K_VALID);
        repeat (20) @(negedge clk);
`endif

        for (int i = 0; i < 600 && expq.size() > 0; i++) @(negedge clk);
        total_checks++;
        if (expq.size() != 0) begin
            bad_checks++;
            $display("[TB] FAIL missing pulses: got %0d outstanding, expected 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
